// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the two-master memory arbiter: two native-handshake
// master ports (m0 = CPU, m1 = loader/DMA) and the single downstream port.
//
// Handshake: a master raises mX_valid with addr/wdata/wstrb and holds them
// stable until mX_ready pulses for one cycle (rdata valid in that same
// cycle); wstrb==0 means read. Downstream sees the same protocol on s_*.
interface mem_bus_arbiter_if;
  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  // Arbiter view: receives master requests, drives the downstream port.
  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  // Environment view: both masters plus the downstream memory/MMIO decode.
  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of one native-handshake memory
// port. A grant is taken in IDLE, held in BUSY until the downstream
// completes, the owner drops its request, or the watchdog forces an error
// completion after TIMEOUT_CYCLES BUSY cycles.
module mem_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              resetn,
  mem_bus_arbiter_if.slave  bus,
  output logic [1:0]        grant,
  output logic              err_flag,
  output logic [31:0]       err_addr,
  input  logic              err_clr,
  output logic              state_dbg
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  logic          last_m1;   // 1 when master 1 owned the last completed transaction
  logic [CW-1:0] cnt;

  logic          busy;
  logic          sel_m1;
  logic          sel_valid;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          done;
  logic          tmo;
  logic          finish;
  logic [31:0]   fin_data;

  // Steer the granted master onto the downstream port and classify this cycle.
  always_comb begin
    busy      = (state == BUSY);
    sel_m1    = grant[1];
    sel_valid = sel_m1 ? bus.m1_valid : bus.m0_valid;
    sel_addr  = sel_m1 ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
    sel_wstrb = sel_m1 ? bus.m1_wstrb : bus.m0_wstrb;
    done      = busy && sel_valid && bus.s_ready;
    // A ready arriving on the last allowed cycle wins over the watchdog.
    tmo       = busy && sel_valid && !bus.s_ready && (cnt == CNT_LAST);
    finish    = done || tmo;
    fin_data  = done ? bus.s_rdata : ERR_DATA;
  end

  assign bus.s_valid  = busy && sel_valid;
  assign bus.s_addr   = busy ? sel_addr  : 32'h0;
  assign bus.s_wdata  = busy ? sel_wdata : 32'h0;
  assign bus.s_wstrb  = busy ? sel_wstrb : 4'h0;

  assign bus.m0_ready = finish && grant[0];
  assign bus.m0_rdata = (finish && grant[0]) ? fin_data : 32'h0;
  assign bus.m1_ready = finish && grant[1];
  assign bus.m1_rdata = (finish && grant[1]) ? fin_data : 32'h0;

  assign state_dbg    = busy;

  // Arbitration FSM, watchdog counter and sticky error capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= 2'b00;
      last_m1  <= 1'b1;
      cnt      <= '0;
      err_flag <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      // Clear first so a same-cycle timeout below overrides it.
      if (err_clr) err_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m0_valid || bus.m1_valid) begin
            state <= BUSY;
            cnt   <= '0;
            if (bus.m0_valid && bus.m1_valid)
              grant <= last_m1 ? 2'b01 : 2'b10;
            else
              grant <= bus.m1_valid ? 2'b10 : 2'b01;
          end
        end
        BUSY: begin
          if (!sel_valid) begin
            // Owner withdrew: abort silently, fairness history untouched.
            state <= IDLE;
            grant <= 2'b00;
          end else if (finish) begin
            state   <= IDLE;
            grant   <= 2'b00;
            last_m1 <= sel_m1;
            if (tmo) begin
              err_flag <= 1'b1;
              err_addr <= sel_addr;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: queue-driven masters, a programmable downstream
// responder, a cycle-level reference model with a per-cycle compare, and
// directed tests with literal expectations.
module tb_mem_bus_arbiter;
  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  hold;   // give up after this many granted cycles, 0 = never
  } req_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        err_clr;
  logic [1:0]  grant;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        state_dbg;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .grant    (grant),
    .err_flag (err_flag),
    .err_addr (err_addr),
    .err_clr  (err_clr),
    .state_dbg(state_dbg)
  );

  // ---------------- shared bench state ----------------
  req_t        q0[$];
  req_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          sv_cycles;
  logic [31:0] trace_word;
  logic [1:0]  trace_last;
  logic [35:0] cap_w1;
  int          resp_delay;
  logic [31:0] resp_data;

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [7:0] h);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s; r.hold = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: master 0 ----------------
  initial begin : drv0
    logic d;
    int   gc;
    gc = 0;
    bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
    forever begin
      @(negedge clk);
      d = bus.m0_ready;
      if (grant == 2'b01) gc++;
      @(posedge clk); #1;
      if (q0.size() > 0 && (d || (q0[0].hold != 0 && gc >= int'(q0[0].hold)))) begin
        void'(q0.pop_front());
        gc = 0;
      end
      if (q0.size() > 0) begin
        bus.m0_valid = 1'b1; bus.m0_addr = q0[0].addr;
        bus.m0_wdata = q0[0].wdata; bus.m0_wstrb = q0[0].wstrb;
      end else begin
        bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
        gc = 0;
      end
    end
  end

  // ---------------- driver: master 1 ----------------
  initial begin : drv1
    logic d;
    int   gc;
    gc = 0;
    bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    forever begin
      @(negedge clk);
      d = bus.m1_ready;
      if (grant == 2'b10) gc++;
      @(posedge clk); #1;
      if (q1.size() > 0 && (d || (q1[0].hold != 0 && gc >= int'(q1[0].hold)))) begin
        void'(q1.pop_front());
        gc = 0;
      end
      if (q1.size() > 0) begin
        bus.m1_valid = 1'b1; bus.m1_addr = q1[0].addr;
        bus.m1_wdata = q1[0].wdata; bus.m1_wstrb = q1[0].wstrb;
      end else begin
        bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
        gc = 0;
      end
    end
  end

  // ---------------- downstream responder ----------------
  // Asserts s_ready on the resp_delay-th cycle of s_valid (never when 0).
  initial begin : resp
    int n;
    n = 0;
    bus.s_ready = 1'b0; bus.s_rdata = '0;
    forever begin
      @(posedge clk); #3;
      if (bus.s_valid) n++; else n = 0;
      bus.s_ready = (resp_delay != 0 && n == resp_delay);
      bus.s_rdata = bus.s_ready ? resp_data : 32'h0;
    end
  end

  // ---------------- reference model ----------------
  // owner: -1 idle, 0/1 = master; age = BUSY cycles already spent.
  int          m_own   = -1;
  int          m_age   = 0;
  int          m_last  = 1;
  logic        m_err   = 1'b0;
  logic [31:0] m_eaddr = 32'h0;

  initial begin : model
    logic        ov;
    logic [31:0] oa;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_own = -1; m_age = 0; m_last = 1; m_err = 1'b0; m_eaddr = 32'h0;
      end else begin
        if (err_clr) m_err = 1'b0;
        if (m_own < 0) begin
          if (bus.m0_valid && bus.m1_valid) m_own = 1 - m_last;
          else if (bus.m1_valid)            m_own = 1;
          else if (bus.m0_valid)            m_own = 0;
          m_age = 0;
        end else begin
          ov = (m_own == 0) ? bus.m0_valid : bus.m1_valid;
          oa = (m_own == 0) ? bus.m0_addr  : bus.m1_addr;
          if (!ov) m_own = -1;
          else if (bus.s_ready) begin m_last = m_own; m_own = -1; end
          else if (m_age == T - 1) begin
            m_err = 1'b1; m_eaddr = oa; m_last = m_own; m_own = -1;
          end else m_age++;
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  initial begin : cmp
    logic        busy, ov, norm, to, r0, r1;
    logic [31:0] fd;
    forever begin
      @(negedge clk);
      busy = (m_own >= 0);
      ov   = busy && ((m_own == 0) ? bus.m0_valid : bus.m1_valid);
      norm = ov && bus.s_ready;
      to   = ov && !bus.s_ready && (m_age == T - 1);
      fd   = norm ? bus.s_rdata : ERR;
      r0   = (norm || to) && m_own == 0;
      r1   = (norm || to) && m_own == 1;
      check("grant",    grant, !busy ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10));
      check("state",    state_dbg, busy);
      check("s_valid",  bus.s_valid, ov);
      check("s_addr",   bus.s_addr,  !busy ? 32'h0 : (m_own == 0 ? bus.m0_addr  : bus.m1_addr));
      check("s_wdata",  bus.s_wdata, !busy ? 32'h0 : (m_own == 0 ? bus.m0_wdata : bus.m1_wdata));
      check("s_wstrb",  bus.s_wstrb, !busy ? 4'h0  : (m_own == 0 ? bus.m0_wstrb : bus.m1_wstrb));
      check("m0_ready", bus.m0_ready, r0);
      check("m0_rdata", bus.m0_rdata, r0 ? fd : 32'h0);
      check("m1_ready", bus.m1_ready, r1);
      check("m1_rdata", bus.m1_rdata, r1 ? fd : 32'h0);
      check("err_flag", err_flag, m_err);
      check("err_addr", err_addr, m_eaddr);
      // monitor for the directed tests
      if (bus.m0_ready) got_q.push_back({1'b0, bus.m0_rdata});
      if (bus.m1_ready) got_q.push_back({1'b1, bus.m1_rdata});
      if (bus.s_valid) sv_cycles++;
      if (grant != trace_last) begin
        trace_word = {trace_word[29:0], grant};
        trace_last = grant;
      end
      if (grant == 2'b10) cap_w1 = {bus.s_wstrb, bus.s_wdata};
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic begin_test();
    sv_cycles  = 0;
    trace_word = 32'h0;
    trace_last = grant;
    cap_w1     = 36'h0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_drained(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00 && resetn) ok = 1'b1;
    end
    tick();
    check({name, "_drain"}, ok, 1'b1);
  endtask

  task automatic check_comp(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_txn"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    bit seen;
    resetn = 1'b0; err_clr = 1'b0; resp_delay = 0; resp_data = 32'h0;
    sv_cycles = 0; trace_word = 32'h0; trace_last = 2'b00; cap_w1 = 36'h0;
    @(negedge clk);
    check("rst_grant",   grant, 2'b00);
    check("rst_s_valid", bus.s_valid, 1'b0);
    check("rst_err",     {err_flag, err_addr}, 33'h0);
    check("rst_ready",   {bus.m0_ready, bus.m1_ready}, 2'b00);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // T1: lone m0 read, ready on 2nd BUSY cycle
    begin_test();
    resp_delay = 2; resp_data = 32'h1234_5678;
    q0.push_back(mk(32'h100, 32'h0, 4'h0, 8'd0));
    wait_drained("t1", 40);
    exp_q.push_back({1'b0, 32'h1234_5678});
    check_comp("t1");
    check("t1_sv_cycles", sv_cycles, 2);
    check("t1_grant_seq", trace_word, 32'h4);

    // T2: both valid in first cycle after reset -> m0, idle, m1
    resetn = 1'b0;
    begin_test();
    resp_delay = 1; resp_data = 32'hCAFE_0001;
    q0.push_back(mk(32'h400, 32'h0, 4'h0, 8'd0));
    q1.push_back(mk(32'h500, 32'h0, 4'h0, 8'd0));
    tick(); tick();
    resetn = 1'b1;
    wait_drained("t2", 40);
    exp_q.push_back({1'b0, 32'hCAFE_0001});
    exp_q.push_back({1'b1, 32'hCAFE_0001});
    check_comp("t2");
    check("t2_grant_seq", trace_word, 32'h48);
    check("t2_sv_cycles", sv_cycles, 2);

    // T3: m0 streaming, m1 byte write pending -> m0,m1,m0,m0
    begin_test();
    resp_delay = 1; resp_data = 32'h55;
    q0.push_back(mk(32'h200, 32'h0, 4'h0, 8'd0));
    q0.push_back(mk(32'h204, 32'h0, 4'h0, 8'd0));
    q0.push_back(mk(32'h208, 32'h0, 4'h0, 8'd0));
    q1.push_back(mk(32'h1000_0000, 32'h41, 4'b0001, 8'd0));
    wait_drained("t3", 60);
    exp_q.push_back({1'b0, 32'h55});
    exp_q.push_back({1'b1, 32'h55});
    exp_q.push_back({1'b0, 32'h55});
    exp_q.push_back({1'b0, 32'h55});
    check_comp("t3");
    check("t3_grant_seq", trace_word, 32'h4844);
    check("t3_m1_write",  cap_w1, {4'b0001, 32'h41});

    // T4: m1 read hangs -> error completion on 8th BUSY cycle
    begin_test();
    resp_delay = 0;
    q1.push_back(mk(32'h2000, 32'h0, 4'h0, 8'd0));
    wait_drained("t4", 40);
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    check_comp("t4");
    check("t4_sv_cycles", sv_cycles, 8);
    @(negedge clk);
    check("t4_err_flag", err_flag, 1'b1);
    check("t4_err_addr", err_addr, 32'h2000);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t4_err_clr",  err_flag, 1'b0);
    check("t4_addr_kept", err_addr, 32'h2000);
    tick();

    // T5: ready exactly on 8th BUSY cycle -> normal completion
    begin_test();
    resp_delay = 8; resp_data = 32'h0BAD_F00D;
    q0.push_back(mk(32'h3000, 32'h0, 4'h0, 8'd0));
    wait_drained("t5", 40);
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    check_comp("t5");
    check("t5_sv_cycles", sv_cycles, 8);
    @(negedge clk);
    check("t5_err_flag", err_flag, 1'b0);
    tick();

    // T6: m1 withdraws mid-BUSY -> silent abort, fairness unchanged
    begin_test();
    resp_delay = 0;
    q1.push_back(mk(32'h4000, 32'h0, 4'h0, 8'd1));
    wait_drained("t6", 40);
    check_comp("t6");
    check("t6_sv_cycles", sv_cycles, 1);
    check("t6_grant_seq", trace_word, 32'h8);
    check("t6_err_flag",  err_flag, 1'b0);
    begin_test();
    resp_delay = 1; resp_data = 32'h66;
    q0.push_back(mk(32'h4100, 32'h0, 4'h0, 8'd0));
    q1.push_back(mk(32'h4200, 32'h0, 4'h0, 8'd0));
    wait_drained("t6b", 40);
    exp_q.push_back({1'b1, 32'h66});
    exp_q.push_back({1'b0, 32'h66});
    check_comp("t6b");

    // T7: reset while m1 is BUSY, then m0 wins the first tie
    begin_test();
    resp_delay = 0;
    q1.push_back(mk(32'h5000, 32'h0, 4'h0, 8'd0));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (grant == 2'b10) seen = 1'b1;
    end
    check("t7_busy_seen", seen, 1'b1);
    tick();
    resetn = 1'b0;
    #1;
    check("t7_rst_s_valid", bus.s_valid, 1'b0);
    check("t7_rst_grant",   grant, 2'b00);
    check("t7_rst_ready",   {bus.m0_ready, bus.m1_ready}, 2'b00);
    check("t7_rst_state",   state_dbg, 1'b0);
    q0.delete();
    q1.delete();
    tick(); tick();
    begin_test();
    resp_delay = 1; resp_data = 32'h77;
    q0.push_back(mk(32'h600, 32'h0, 4'h0, 8'd0));
    q1.push_back(mk(32'h700, 32'h0, 4'h0, 8'd0));
    resetn = 1'b1;
    wait_drained("t7", 40);
    exp_q.push_back({1'b0, 32'h77});
    exp_q.push_back({1'b1, 32'h77});
    check_comp("t7");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- global time bound ----------------
  initial begin : guard
    #200000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "bench time bound expired");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing one native-handshake memory/MMIO port (valid/ready/addr/wdata/wstrb/rdata, picorv32 style) between the CPU (m0) and a second master such as a loader/DMA (m1).
- Sits between the masters and the memory/MMIO decode logic.
- Grants round-robin and holds each grant until the transaction completes.
- A watchdog completes hung transactions with an error word and records the address.

Parameters:
- TIMEOUT_CYCLES, 256, cycles a granted transaction may wait for s_ready before forced completion (>=2).
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous reset, active-low.
- m0_valid  in  1  master 0 request.
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0 = read.
- m0_ready  out  1  master 0 completion pulse.
- m0_rdata  out  32  master 0 read data, valid with m0_ready.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0, for master 1.
- s_valid  out  1  downstream request.
- s_addr  out  32  downstream address.
- s_wdata  out  32  downstream write data.
- s_wstrb  out  4  downstream strobes.
- s_ready  in  1  downstream completion.
- s_rdata  in  32  downstream read data.
- grant  out  2  one-hot owner, 00 when idle.
- err_flag  out  1  sticky timeout flag.
- err_addr  out  32  address of the most recent timed-out transaction.
- err_clr  in  1  clears err_flag.

Behaviour:
- Reset (resetn low, async): state IDLE, grant=00, last_grant=m1 (so m0 wins first), counter 0, err_flag 0, err_addr 0. All ready/valid outputs 0.
- States: IDLE, BUSY.
- IDLE, arbitration:
  - If only one m*_valid is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - The grant registers at the clock edge; go to BUSY with counter=0.
  - No downstream activity while in IDLE.
- BUSY, request forwarding:
  - s_valid=1.
  - s_addr, s_wdata, s_wstrb pass combinationally from the granted master. Masters hold these stable while valid.
- BUSY, completion: when s_ready=1:
  - The granted m*_ready=1 combinationally in the same cycle, and its m*_rdata=s_rdata.
  - Next state IDLE; last_grant = granted master.
- BUSY, timeout: if s_ready=0 and counter==TIMEOUT_CYCLES-1:
  - Granted m*_ready=1 with m*_rdata=ERR_DATA.
  - err_flag<=1, err_addr<=granted address, last_grant updated, next state IDLE.
  - Otherwise counter increments each BUSY cycle.
  - Result: a hung transaction completes on its TIMEOUT_CYCLES-th BUSY cycle.
- s_ready on the timeout cycle counts as normal completion: s_rdata returned, no error.
- Granted master drops valid in BUSY without s_ready: abort, no ready pulse, no error, next state IDLE, last_grant unchanged.
- Non-granted master: ready=0, rdata=0. s_* outputs are 0 in IDLE.
- Every transaction takes at least 2 cycles (IDLE grant + BUSY). One idle cycle separates back-to-back transactions, so downstream never sees valid asserted in the cycle after ready.
- err_clr: clears err_flag next edge. If a timeout occurs in the same cycle, set wins. err_addr is never cleared except by reset.
- A late s_ready after a timeout, arriving in IDLE, is ignored.
- Reset mid-BUSY: all outputs drop immediately; the transaction is lost.

Test Plan:
- m0 read of addr 0x100 alone; downstream asserts s_ready with s_rdata=0x12345678 on its 2nd BUSY cycle -> s_valid high 2 cycles, m0_ready single pulse with m0_rdata=0x12345678, grant returns 00.
- m0 and m1 both valid in the first cycle after reset; downstream ready on the 1st BUSY cycle -> m0 served first, then one IDLE cycle, then m1; grant sequence 01,00,10.
- m0 requests continuously while m1 write (0x10000000, wstrb=0001, wdata=0x41) is pending -> grants alternate m0,m1,m0; s_wstrb=0001 and s_wdata=0x41 during m1 BUSY.
- TIMEOUT_CYCLES=8, m1 read of 0x2000 with s_ready stuck 0 -> m1_ready on 8th BUSY cycle, m1_rdata=0xDEADBEEF, err_flag=1, err_addr=0x2000; pulse err_clr -> err_flag=0.
- TIMEOUT_CYCLES=8, s_ready asserted exactly on 8th BUSY cycle -> normal rdata, err_flag stays 0.
- Assert resetn low mid-BUSY -> s_valid, grant, and ready outputs 0 asynchronously; after release m0 wins the first simultaneous request.
